// File: rtl/lcd_hex_display.sv
// lcd_hex_display: drives a 16x2 character LCD with two labelled hex values, init sequence after reset
module lcd_hex_display #(
    parameter int DATA_W = 32,
    parameter int T_EN = 16,
    parameter int T_CMD = 2500,
    parameter int T_INIT = 30000,
    parameter int AUTO_REFRESH = 0,
    parameter logic [127:0] LABEL0 = "out_val:        ",
    parameter logic [127:0] LABEL1 = "PC:             "
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] val0,
    input  logic [DATA_W-1:0] val1,
    output logic              busy,
    output logic              done,
    output logic [7:0]        LCD_DATA,
    output logic              LCD_RS,
    output logic              LCD_EN,
    output logic              LCD_RW
);
    localparam int ND = DATA_W / 4;
    localparam int NL = 16 - ND;
    localparam int TM0 = (T_INIT > T_CMD) ? T_INIT : T_CMD;
    localparam int TMAX = (TM0 > T_EN) ? TM0 : T_EN;
    localparam int CW = $clog2(TMAX + 2);
    localparam logic [CW-1:0] C_EN = CW'(T_EN);
    localparam logic [CW-1:0] C_CMD = CW'(T_CMD);
    localparam logic [CW-1:0] C_INIT = CW'(T_INIT);

    typedef enum logic [1:0] {IDLE, INIT, FRAME} top_t;
    typedef enum logic [2:0] {P_IDLE, P_SETUP, P_HOLD, P_EN, P_WAIT} ph_t;

    top_t top, top_n;
    ph_t ph, ph_n;
    logic [5:0] idx, idx_n;
    logic [CW-1:0] cnt, cnt_n, wait_end;
    logic [DATA_W-1:0] snap0, snap0_n, snap1, snap1_n;
    logic last_w, frame_go, done_n, rs_n;
    logic [7:0] data_n;

    function automatic logic [7:0] hex_ch(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // Write i of the current sequence as {RS, DATA}; frame writes 1-16 and 18-33 are characters.
    function automatic logic [8:0] wr_word(input top_t t, input logic [5:0] i,
                                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [3:0] p;
        logic [127:0] lab;
        logic [DATA_W-1:0] v;
        if (t == INIT)
            return {1'b0, (i == 6'd0) ? 8'h38 : (i == 6'd1) ? 8'h0C : (i == 6'd2) ? 8'h01 : 8'h06};
        if (i == 6'd0)
            return 9'h080;
        if (i == 6'd17)
            return 9'h0C0;
        p = (i < 6'd17) ? 4'(i - 6'd1) : 4'(i - 6'd18);
        lab = (i < 6'd17) ? LABEL0 : LABEL1;
        v = (i < 6'd17) ? a : b;
        if (int'(p) < NL)
            return {1'b1, 8'(lab >> (8 * (15 - int'(p))))};
        return {1'b1, hex_ch(4'(v >> (4 * (15 - int'(p)))))};
    endfunction

    always_comb begin
        top_n = top;
        ph_n = ph;
        idx_n = idx;
        cnt_n = cnt + 1'b1;
        snap0_n = snap0;
        snap1_n = snap1;
        last_w = (top == INIT) ? (idx == 6'd3) : (idx == 6'd33);
        wait_end = (top == INIT) ? C_INIT : C_CMD;
        frame_go = 1'b0;
        case (ph)
            P_IDLE: begin
                cnt_n = '0;
                ph_n = (top == INIT || start) ? P_SETUP : P_IDLE;
                frame_go = (top == IDLE) && start;
            end
            P_SETUP: begin
                cnt_n = '0;
                ph_n = P_HOLD;
            end
            P_HOLD: begin
                cnt_n = '0;
                ph_n = P_EN;
            end
            P_EN: if (cnt == C_EN) begin
                cnt_n = '0;
                ph_n = P_WAIT;
            end
            default: if (cnt == wait_end) begin
                cnt_n = '0;
                idx_n = last_w ? 6'd0 : idx + 6'd1;
                frame_go = last_w && (top == INIT || AUTO_REFRESH != 0);
                ph_n = (last_w && !frame_go) ? P_IDLE : P_SETUP;
                top_n = (last_w && !frame_go) ? IDLE : top;
            end
        endcase
        if (frame_go) begin
            top_n = FRAME;
            snap0_n = val0;
            snap1_n = val1;
        end
        done_n = (top_n == FRAME) && (idx_n == 6'd33) && (ph_n == P_WAIT) && (cnt_n == C_CMD);
    end

    // Outputs are registered from next-state so DATA/RS are already valid in the SETUP cycle.
    always_comb {rs_n, data_n} = (ph_n == P_IDLE) ? {LCD_RS, LCD_DATA} : wr_word(top_n, idx_n, snap0_n, snap1_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            top <= INIT;
            ph <= P_IDLE;
            idx <= '0;
            cnt <= '0;
            snap0 <= '0;
            snap1 <= '0;
            LCD_DATA <= '0;
            LCD_RS <= 1'b0;
            LCD_EN <= 1'b0;
            done <= 1'b0;
        end else begin
            top <= top_n;
            ph <= ph_n;
            idx <= idx_n;
            cnt <= cnt_n;
            snap0 <= snap0_n;
            snap1 <= snap1_n;
            LCD_DATA <= data_n;
            LCD_RS <= rs_n;
            LCD_EN <= (ph_n == P_EN);
            done <= done_n;
        end
    end

    assign busy = (top != IDLE);
    assign LCD_RW = 1'b0;
endmodule
